// File: rtl/bp_me_pkg.sv
// bp_me_pkg: shared types and width helpers for the BedRock stream arbiter.
//   bp_me_stream_arb_state_e : arbiter state (free to pick a source / holding a message)
//   safe_clog2               : clog2 that never returns 0, so 1-entry indices stay 1 bit wide
//   bp_me_header_width       : BedRock stream header width (type, subop, addr, size, payload)
package bp_me_pkg;

    typedef enum logic {e_free, e_hold} bp_me_stream_arb_state_e;

    localparam int bp_me_msg_type_width_lp  = 4;
    localparam int bp_me_msg_subop_width_lp = 4;
    localparam int bp_me_msg_size_width_lp  = 3;

    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int bp_me_header_width(input int paddr_w, input int payload_w);
        return bp_me_msg_type_width_lp + bp_me_msg_subop_width_lp + paddr_w
             + bp_me_msg_size_width_lp + payload_w;
    endfunction

endpackage

// File: rtl/bp_me_rr_select.sv
// bp_me_rr_select: combinational one-hot round-robin select.
//   ptr_i   : index with highest priority this cycle
//   req_i   : request vector
//   grant_o : one-hot grant of the first request at or above ptr_i, wrapping; zero if none
module bp_me_rr_select
    import bp_me_pkg::*;
#(
    parameter int n_p = 2,
    localparam int ptr_w_lp = safe_clog2(n_p)
) (
    input  logic [ptr_w_lp-1:0] ptr_i,
    input  logic [n_p-1:0]      req_i,
    output logic [n_p-1:0]      grant_o
);

    // Walk from the lowest priority offset down so the closest request to ptr_i wins.
    always_comb begin
        int idx;
        logic [ptr_w_lp-1:0] idx_w;
        grant_o = '0;
        idx     = 0;
        idx_w   = '0;
        for (int i = n_p - 1; i >= 0; i--) begin
            idx   = int'(ptr_i) + i;
            idx   = (idx >= n_p) ? idx - n_p : idx;
            idx_w = ptr_w_lp'(idx);
            if (req_i[idx_w]) grant_o = n_p'(1) << idx_w;
        end
    end

endmodule

// File: rtl/bp_me_stream_arbiter.sv
// bp_me_stream_arbiter: round-robin share of one BedRock stream channel, grant held per message.
//   clk_i, reset_i        : clock, synchronous active-high reset
//   in_msg_header_i/data_i: per-source header/beat data, source i in slice i
//   in_msg_v_i/lock_i     : per-source valid; lock = more beats of this message follow
//   in_msg_ready_and_o    : per-source ready, only ever to the granted source
//   out_msg_*             : granted source passed straight through to the sink
//   grant_one_hot_o       : current grant, zero when nothing is granted
module bp_me_stream_arbiter
    import bp_me_pkg::*;
#(
    parameter int num_ports_p         = 2,
    parameter int data_width_p        = 64,
    parameter int payload_width_p     = 1,
    parameter int paddr_width_p       = 40,
    parameter int msg_header_width_lp = bp_me_header_width(paddr_width_p, payload_width_p)
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [num_ports_p*msg_header_width_lp-1:0] in_msg_header_i,
    input  logic [num_ports_p*data_width_p-1:0]    in_msg_data_i,
    input  logic [num_ports_p-1:0]                 in_msg_v_i,
    input  logic [num_ports_p-1:0]                 in_msg_lock_i,
    output logic [num_ports_p-1:0]                 in_msg_ready_and_o,
    output logic [msg_header_width_lp-1:0]         out_msg_header_o,
    output logic [data_width_p-1:0]                out_msg_data_o,
    output logic                                   out_msg_v_o,
    input  logic                                   out_msg_ready_and_i,
    output logic                                   out_msg_lock_o,
    output logic [num_ports_p-1:0]                 grant_one_hot_o
);

    localparam int ptr_w_lp = safe_clog2(num_ports_p);

    bp_me_stream_arb_state_e state_q, state_d;
    logic [ptr_w_lp-1:0]     ptr_q, ptr_d, owner_q, owner_d, sel_idx, g, g_inc;
    logic [num_ports_p-1:0]  sel_oh, grant_oh;
    logic                    hs, lock;
    logic [msg_header_width_lp-1:0] hdr_a [num_ports_p];
    logic [data_width_p-1:0]        data_a [num_ports_p];

    for (genvar i = 0; i < num_ports_p; i++) begin : g_unpack
        assign hdr_a[i]  = in_msg_header_i[i*msg_header_width_lp +: msg_header_width_lp];
        assign data_a[i] = in_msg_data_i[i*data_width_p +: data_width_p];
    end

    bp_me_rr_select #(.n_p(num_ports_p)) u_sel (
        .ptr_i  (ptr_q),
        .req_i  (in_msg_v_i),
        .grant_o(sel_oh)
    );

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < num_ports_p; i++) if (sel_oh[i]) sel_idx = ptr_w_lp'(i);
    end

    // In e_hold the owner keeps the grant even while its valid is low between beats.
    assign g        = (state_q == e_hold) ? owner_q : sel_idx;
    assign g_inc    = (g == ptr_w_lp'(num_ports_p - 1)) ? '0 : g + 1'b1;
    assign grant_oh = reset_i ? '0 : (state_q == e_hold) ? (num_ports_p'(1) << owner_q) : sel_oh;

    assign out_msg_v_o        = |(grant_oh & in_msg_v_i);
    assign lock               = in_msg_lock_i[g];
    assign out_msg_lock_o     = out_msg_v_o & lock;
    assign hs                 = out_msg_v_o & out_msg_ready_and_i;
    assign in_msg_ready_and_o = grant_oh & {num_ports_p{out_msg_ready_and_i}};
    assign out_msg_header_o   = hdr_a[g];
    assign out_msg_data_o     = data_a[g];
    assign grant_one_hot_o    = grant_oh;

    // A beat presented in e_free that is not the last of a completed message pins the
    // grant, so a stalled beat is never retracted or swapped for another source.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        if (state_q == e_free) begin
            if (out_msg_v_o) begin
                if (hs && !lock) begin
                    ptr_d = g_inc;
                end else begin
                    state_d = e_hold;
                    owner_d = g;
                end
            end
        end else if (hs && !lock) begin
            state_d = e_free;
            ptr_d   = g_inc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_free;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

`ifndef SYNTHESIS
    logic lock_prev_q, hs_prev_q;

    // Lock may only change in the cycle following a handshake of the beat it described.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lock_prev_q <= 1'b0;
            hs_prev_q   <= 1'b0;
        end else begin
            lock_prev_q <= lock;
            hs_prev_q   <= hs;
            assert (num_ports_p >= 2) else $error("bp_me_stream_arbiter: num_ports_p must be >= 2");
            assert (!(state_q == e_hold && lock_prev_q && !lock && !hs_prev_q))
                else $error("bp_me_stream_arbiter: owner lock dropped without a beat");
        end
    end
`endif

endmodule

// File: tb/tb_bp_me_stream_arbiter.sv
// tb_bp_me_stream_arbiter: randomized sources and sink against a message-level reference model.
module tb_bp_me_stream_arbiter;
    import bp_me_pkg::*;

    localparam int N  = 3;
    localparam int DW = 16;
    localparam int PA = 12;
    localparam int HW = bp_me_header_width(PA, 1);

    logic clk, rst;
    logic [N*HW-1:0] hdr_bus;
    logic [N*DW-1:0] data_bus;
    logic [N-1:0]    v_bus, lock_bus, rdy_o, gnt_o;
    logic [HW-1:0]   out_hdr;
    logic [DW-1:0]   out_data;
    logic            out_v, out_rdy, out_lock;

    bp_me_stream_arbiter #(
        .num_ports_p    (N),
        .data_width_p   (DW),
        .payload_width_p(1),
        .paddr_width_p  (PA)
    ) dut (
        .clk_i              (clk),
        .reset_i            (rst),
        .in_msg_header_i    (hdr_bus),
        .in_msg_data_i      (data_bus),
        .in_msg_v_i         (v_bus),
        .in_msg_lock_i      (lock_bus),
        .in_msg_ready_and_o (rdy_o),
        .out_msg_header_o   (out_hdr),
        .out_msg_data_o     (out_data),
        .out_msg_v_o        (out_v),
        .out_msg_ready_and_i(out_rdy),
        .out_msg_lock_o     (out_lock),
        .grant_one_hot_o    (gnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Source state: one message in flight per source, beats numbered from 0.
    int        act [N];
    int        len [N];
    int        beat[N];
    int        msg [N];
    bit        vq  [N];
    logic [HW-1:0] hdr[N];

    // Reference model: rr pointer and message owner (-1 = nobody holds the channel).
    int ptr, own, last_port;
    bit last_lock;

    function automatic logic [DW-1:0] dval(input int p);
        return {4'(p), 4'(msg[p]), 8'(beat[p])};
    endfunction

    initial begin
        int g, vprob;
        bit ev, ehs, el;
        logic [N-1:0] eg, er;
        rst = 1'b1; out_rdy = 1'b1;
        hdr_bus = '0; data_bus = '0; v_bus = '0; lock_bus = '0;
        for (int p = 0; p < N; p++) begin
            act[p] = 0; len[p] = 0; beat[p] = 0; msg[p] = 0; vq[p] = 0; hdr[p] = '0;
        end
        ptr = 0; own = -1; last_port = 0; last_lock = 0;
        @(negedge clk);
        v_bus = '1;
        #1;
        check("rst_v", 64'(out_v), 64'd0);
        check("rst_ready", 64'(rdy_o), 64'd0);
        check("rst_grant", 64'(gnt_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        v_bus = '0;
        #1;
        check("post_rst_v", 64'(out_v), 64'd0);
        check("post_rst_grant", 64'(gnt_o), 64'd0);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc > 0) @(negedge clk);
            vprob   = (cyc < 600) ? 100 : 50;
            out_rdy = (cyc < 600) ? 1'b1 : ($urandom_range(0, 9) < 7);
            rst     = (cyc >= 600) && ($urandom_range(0, 149) == 0);
            for (int p = 0; p < N; p++) begin
                if (act[p] == 0 && (vprob == 100 || $urandom_range(0, 3) == 0)) begin
                    act[p] = 1; len[p] = $urandom_range(1, 4); beat[p] = 0;
                    msg[p]++; hdr[p] = HW'($urandom);
                end
                if (act[p] != 0 && !vq[p] && $urandom_range(0, 99) < vprob) vq[p] = 1;
                v_bus[p]    = vq[p];
                lock_bus[p] = (act[p] != 0) && (beat[p] < len[p] - 1);
                hdr_bus[p*HW +: HW]  = hdr[p];
                data_bus[p*DW +: DW] = dval(p);
            end
            #1;
            g = -1;
            if (!rst) begin
                if (own >= 0) g = own;
                else for (int k = 0; k < N; k++) if (g < 0 && v_bus[(ptr + k) % N]) g = (ptr + k) % N;
            end
            ev  = (g >= 0) && vq[g];
            eg  = (g >= 0) ? N'(1) << g : '0;
            er  = (g >= 0 && out_rdy) ? eg : '0;
            el  = ev && lock_bus[g];
            ehs = ev && out_rdy;
            check("grant", 64'(gnt_o), 64'(eg));
            check("out_v", 64'(out_v), 64'(ev));
            check("ready", 64'(rdy_o), 64'(er));
            check("out_lock", 64'(out_lock), 64'(el));
            if (ev) begin
                check("data", 64'(out_data), 64'(dval(g)));
                check("header", 64'(out_hdr), 64'(hdr[g]));
            end
            if (ehs && last_lock) check("no_interleave", 64'(g), 64'(last_port));
            @(posedge clk);
            if (rst) begin
                ptr = 0; own = -1; last_lock = 0;
                for (int p = 0; p < N; p++) begin act[p] = 0; vq[p] = 0; end
            end else begin
                if (own < 0) begin
                    if (ev) begin
                        if (ehs && !el) ptr = (g + 1) % N;
                        else own = g;
                    end
                end else if (ehs && !el) begin
                    own = -1; ptr = (g + 1) % N;
                end
                if (ehs) begin
                    last_lock = el; last_port = g;
                    beat[g]++; vq[g] = 0;
                    if (beat[g] == len[g]) act[g] = 0;
                end
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
